play_tracker: RTL and testbench

Game-progress and judgement engine for the piano game. It advances the song beat counter and drives `beat_cnt` out to the expected-note-count lookup. It counts the notes the player actually plays and judges each press and each beat boundary as hit or miss against the lookup's returned count. It keeps score, combo and miss totals, and declares win or lose at end of song.

---
 rtl/play_tracker_pkg.sv | 30 +++
 rtl/play_tracker_score_unit.sv | 55 +++++
 rtl/play_tracker.sv | 160 ++++++++++++++++
 tb/tb_play_tracker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/play_tracker_pkg.sv
// ============================================================================
// Module      : play_tracker_pkg
// Description : Shared state encodings, counter widths and helpers for the
//               piano-game progress tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package play_tracker_pkg;

  localparam int BEAT_W  = 7;
  localparam int CNT_W   = 6;
  localparam int SCORE_W = 10;
  localparam int MISS_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CHECK = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  function automatic logic [MISS_W-1:0] miss_inc(input logic [MISS_W-1:0] m);
    return (&m) ? m : m + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/play_tracker_score_unit.sv
// ============================================================================
// Module      : score_unit
// Description : Score and combo registers with saturation. Optional macro
//               COMBO_BONUS_EN doubles the hit reward once combo >= COMBO_TH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_unit
  import play_tracker_pkg::*;
#(
  parameter int COMBO_TH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               hit,
  input  logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [CNT_W-1:0]   combo
);

  logic [1:0]       bonus;
  logic [SCORE_W:0] sum;

`ifdef COMBO_BONUS_EN
  localparam logic [CNT_W-1:0] TH = CNT_W'(COMBO_TH);
  // Bonus is decided on the combo level before this hit is counted.
  assign bonus = (combo >= TH) ? 2'd2 : 2'd1;
`else
  logic unused_th;
  assign unused_th = ^COMBO_TH;
  assign bonus     = 2'd1;
`endif

  assign sum = {1'b0, score} + {{(SCORE_W-1){1'b0}}, bonus};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score <= '0;
      combo <= '0;
    end else if (clear) begin
      score <= '0;
      combo <= '0;
    end else if (hit) begin
      score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      combo <= (&combo) ? combo : combo + 6'd1;
    end else if (miss) begin
      combo <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/play_tracker.sv
// ============================================================================
// Module      : play_tracker
// Description : Song progress FSM, beat counter and hit/miss judgement.
//               COMBO_BONUS_EN (in score_unit) enables the combo score bonus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module play_tracker
  import play_tracker_pkg::*;
#(
  parameter int LAST_BEAT = 96,
  parameter int MAX_MISS  = 8,
  parameter int COMBO_TH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               beat_tick,
  input  logic               key_valid,
  input  logic [CNT_W-1:0]   expected_cnt,
  output logic [BEAT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]   played_cnt,
  output logic [SCORE_W-1:0] score,
  output logic [CNT_W-1:0]   combo,
  output logic [MISS_W-1:0]  miss_cnt,
  output logic               judge_valid,
  output logic               judge_hit,
  output logic               game_win,
  output logic               game_over
);

  localparam logic [BEAT_W-1:0] LAST_BEAT_V = BEAT_W'(LAST_BEAT);
  localparam logic [MISS_W-1:0] MAX_MISS_V  = MISS_W'(MAX_MISS);

  state_t              state, state_nxt;
  logic                pending, pending_nxt;
  logic [BEAT_W-1:0]   beat_nxt;
  logic [CNT_W-1:0]    played_nxt;
  logic [MISS_W-1:0]   miss_nxt;
  logic                jv_nxt, jh_nxt, win_nxt, over_nxt;
  logic                hit, miss, clear, press, behind;

  assign behind = (played_cnt < expected_cnt);

  score_unit #(.COMBO_TH(COMBO_TH)) u_score (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .hit   (hit),
    .miss  (miss),
    .score (score),
    .combo (combo)
  );

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    beat_nxt    = beat_cnt;
    played_nxt  = played_cnt;
    miss_nxt    = miss_cnt;
    jv_nxt      = 1'b0;
    jh_nxt      = 1'b0;
    win_nxt     = game_win;
    over_nxt    = game_over;
    hit         = 1'b0;
    miss        = 1'b0;
    clear       = 1'b0;
    press       = 1'b0;

    if (start) begin
      state_nxt   = S_PLAY;
      pending_nxt = 1'b0;
      beat_nxt    = 7'd1;
      played_nxt  = '0;
      miss_nxt    = '0;
      win_nxt     = 1'b0;
      over_nxt    = 1'b0;
      clear       = 1'b1;
    end else begin
      case (state)
        S_PLAY: begin
          // A stored press goes first; a fresh press then waits one cycle.
          press       = pending | key_valid;
          pending_nxt = pending & key_valid;
          if (press) begin
            jv_nxt = 1'b1;
            if (behind) begin
              jh_nxt     = 1'b1;
              hit        = 1'b1;
              played_nxt = played_cnt + 6'd1;
            end else begin
              miss     = 1'b1;
              miss_nxt = miss_inc(miss_cnt);
            end
          end
          if (miss && (miss_nxt >= MAX_MISS_V)) begin
            state_nxt   = S_LOSE;
            over_nxt    = 1'b1;
            pending_nxt = 1'b0;
          end else if (beat_tick) begin
            state_nxt = S_CHECK;
          end
        end

        S_CHECK: begin
          pending_nxt = pending | key_valid;
          if (behind) begin
            miss       = 1'b1;
            jv_nxt     = 1'b1;
            played_nxt = expected_cnt;
            miss_nxt   = miss_inc(miss_cnt);
          end
          if (miss_nxt >= MAX_MISS_V) begin
            state_nxt   = S_LOSE;
            over_nxt    = 1'b1;
            pending_nxt = 1'b0;
          end else if (beat_cnt == LAST_BEAT_V) begin
            state_nxt   = S_WIN;
            win_nxt     = 1'b1;
            over_nxt    = 1'b1;
            pending_nxt = 1'b0;
          end else begin
            state_nxt = S_PLAY;
            beat_nxt  = beat_cnt + 7'd1;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pending     <= 1'b0;
      beat_cnt    <= '0;
      played_cnt  <= '0;
      miss_cnt    <= '0;
      judge_valid <= 1'b0;
      judge_hit   <= 1'b0;
      game_win    <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      beat_cnt    <= beat_nxt;
      played_cnt  <= played_nxt;
      miss_cnt    <= miss_nxt;
      judge_valid <= jv_nxt;
      judge_hit   <= jh_nxt;
      game_win    <= win_nxt;
      game_over   <= over_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_play_tracker.sv
// ============================================================================
// Module      : tb_play_tracker
// Description : Self-checking bench for play_tracker with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_play_tracker;

  localparam int LAST_BEAT = 96;
  localparam int MAX_MISS  = 8;
  localparam int COMBO_TH  = 8;
`ifdef COMBO_BONUS_EN
  localparam bit BONUS         = 1'b1;
  localparam int PERFECT_SCORE = 90;
`else
  localparam bit BONUS         = 1'b0;
  localparam int PERFECT_SCORE = 49;
`endif

  localparam int P_IDLE = 0, P_PLAY = 1, P_CHECK = 2, P_WIN = 3, P_LOSE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, beat_tick = 1'b0, key_valid = 1'b0;
  logic [5:0] expected_cnt;
  logic [6:0] beat_cnt;
  logic [5:0] played_cnt, combo;
  logic [9:0] score;
  logic [3:0] miss_cnt;
  logic       judge_valid, judge_hit, game_win, game_over;

  int tab [0:127];
  assign expected_cnt = 6'(tab[beat_cnt]);

  play_tracker #(.LAST_BEAT(LAST_BEAT), .MAX_MISS(MAX_MISS), .COMBO_TH(COMBO_TH)) dut (
    .clk(clk), .rst(rst), .start(start), .beat_tick(beat_tick), .key_valid(key_valid),
    .expected_cnt(expected_cnt), .beat_cnt(beat_cnt), .played_cnt(played_cnt),
    .score(score), .combo(combo), .miss_cnt(miss_cnt), .judge_valid(judge_valid),
    .judge_hit(judge_hit), .game_win(game_win), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_ph = P_IDLE, m_beat = 0, m_played = 0, m_score = 0, m_combo = 0, m_miss = 0;
  int m_jv = 0, m_jh = 0, m_win = 0, m_over = 0;
  bit press_q[$];

  int n_total = 0, n_pass = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic clear_model(input int ph, input int beat);
    m_ph = ph; m_beat = beat; m_played = 0; m_score = 0; m_combo = 0; m_miss = 0;
    m_jv = 0; m_jh = 0; m_win = 0; m_over = 0;
    press_q.delete();
  endtask

  task automatic judge_press();
    m_jv = 1;
    if (m_played < tab[m_beat]) begin
      m_jh     = 1;
      m_played = m_played + 1;
      m_score  = imin(m_score + ((BONUS && m_combo >= COMBO_TH) ? 2 : 1), 1023);
      m_combo  = imin(m_combo + 1, 63);
    end else begin
      m_jh    = 0;
      m_miss  = imin(m_miss + 1, 15);
      m_combo = 0;
    end
  endtask

  task automatic end_game(input bit win);
    m_ph   = win ? P_WIN : P_LOSE;
    m_win  = win ? 1 : 0;
    m_over = 1;
    press_q.delete();
  endtask

  task automatic model_step(input bit r, input bit st, input bit tk, input bit kv);
    m_jv = 0;
    m_jh = 0;
    if (r) begin
      clear_model(P_IDLE, 0);
    end else if (st) begin
      clear_model(P_PLAY, 1);
    end else if (m_ph == P_PLAY) begin
      if (kv) press_q.push_back(1'b1);
      if (press_q.size() > 0) begin
        void'(press_q.pop_front());
        judge_press();
      end
      if (m_miss >= MAX_MISS) end_game(1'b0);
      else if (tk) m_ph = P_CHECK;
    end else if (m_ph == P_CHECK) begin
      if (kv && press_q.size() == 0) press_q.push_back(1'b1);
      if (m_played < tab[m_beat]) begin
        m_jv     = 1;
        m_played = tab[m_beat];
        m_miss   = imin(m_miss + 1, 15);
        m_combo  = 0;
      end
      if (m_miss >= MAX_MISS) end_game(1'b0);
      else if (m_beat == LAST_BEAT) end_game(1'b1);
      else begin
        m_beat = m_beat + 1;
        m_ph   = P_PLAY;
      end
    end
  endtask

  always @(negedge clk) begin
    chk("beat_cnt", int'(beat_cnt), m_beat);
    chk("played_cnt", int'(played_cnt), m_played);
    chk("score", int'(score), m_score);
    chk("combo", int'(combo), m_combo);
    chk("miss_cnt", int'(miss_cnt), m_miss);
    chk("judge_valid", int'(judge_valid), m_jv);
    if (m_jv != 0) chk("judge_hit", int'(judge_hit), m_jh);
    chk("game_win", int'(game_win), m_win);
    chk("game_over", int'(game_over), m_over);
  end

  task automatic cyc(input bit r, input bit st, input bit tk, input bit kv);
    @(negedge clk);
    #1;
    rst = r; start = st; beat_tick = tk; key_valid = kv;
    @(posedge clk);
    model_step(r, st, tk, kv);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit r, st, tk, kv;
    int since;
    tab[0] = 0; tab[1] = 1; tab[2] = 2; tab[3] = 2; tab[4] = 3; tab[5] = 5;
    for (int b = 6; b < 128; b++) tab[b] = 5;

    // Reset and first hit
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    #1; chk("lit_reset_beat", int'(beat_cnt), 0); chk("lit_reset_over", int'(game_over), 0);
    cyc(0, 1, 0, 0);
    #1; chk("lit_start_beat", int'(beat_cnt), 1); chk("lit_start_score", int'(score), 0);
    cyc(0, 0, 0, 1);
    #1; chk("lit_hit_jh", int'(judge_hit), 1); chk("lit_hit_played", int'(played_cnt), 1);
    chk("lit_hit_score", int'(score), 1); chk("lit_hit_combo", int'(combo), 1);
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    #1; chk("lit_beat2", int'(beat_cnt), 2);
    // Late miss on beat 2
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    #1; chk("lit_late_miss", int'(miss_cnt), 1); chk("lit_late_combo", int'(combo), 0);
    chk("lit_late_played", int'(played_cnt), 2); chk("lit_late_jv", int'(judge_valid), 1);
    chk("lit_late_jh", int'(judge_hit), 0);
    // Early press on beat 3
    cyc(0, 0, 0, 1);
    #1; chk("lit_early_miss", int'(miss_cnt), 2); chk("lit_early_played", int'(played_cnt), 2);
    // Press during CHECK, judged on beat 4
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 1);
    #1; chk("lit_pend_beat", int'(beat_cnt), 4); chk("lit_pend_wait", int'(played_cnt), 2);
    cyc(0, 0, 0, 0);
    #1; chk("lit_pend_jh", int'(judge_hit), 1); chk("lit_pend_played", int'(played_cnt), 3);
    // Pending plus fresh press in the first PLAY cycle of beat 5
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    #1; chk("lit_dbl_played", int'(played_cnt), 5); chk("lit_dbl_combo", int'(combo), 3);
    chk("lit_dbl_score", int'(score), 4);

    // Eight consecutive late misses
    for (int b = 1; b < 128; b++) tab[b] = imin(b, 63);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    end
    #1; chk("lit_lose_over", int'(game_over), 1); chk("lit_lose_win", int'(game_win), 0);
    chk("lit_lose_miss", int'(miss_cnt), 8);
    cyc(0, 0, 1, 1); cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    #1; chk("lit_restart_beat", int'(beat_cnt), 1); chk("lit_restart_over", int'(game_over), 0);

    // Perfect play
    for (int b = 1; b < 128; b++) tab[b] = b / 2 + 1;
    cyc(0, 1, 0, 0);
    for (int b = 1; b <= LAST_BEAT; b++) begin
      for (int k = 0; k < tab[b] - tab[b-1]; k++) cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    end
    #1; chk("lit_win", int'(game_win), 1); chk("lit_win_score", int'(score), PERFECT_SCORE);
    chk("lit_win_beat", int'(beat_cnt), 96); chk("lit_win_played", int'(played_cnt), 49);
    cyc(0, 0, 0, 1); cyc(0, 0, 1, 0);
    #1; chk("lit_win_hold", int'(score), PERFECT_SCORE);

    // Randomized games
    for (int g = 0; g < 8; g++) begin
      tab[0] = 0;
      for (int b = 1; b < 128; b++) tab[b] = imin(tab[b-1] + int'($urandom_range(0, 2)), 63);
      cyc(0, 1, 0, 0);
      since = 2;
      for (int c = 0; c < 3000 && (m_ph == P_PLAY || m_ph == P_CHECK); c++) begin
        r  = (g == 5 && c == 60);
        st = ($urandom_range(0, 599) == 0);
        tk = (m_ph == P_PLAY) && (since >= 2) && ($urandom_range(0, 3) == 0);
        if (m_played < tab[m_beat]) kv = ($urandom_range(0, 9) < 8);
        else                        kv = ($urandom_range(0, 24) == 0);
        cyc(r, st, tk, kv);
        since = tk ? 1 : since + 1;
      end
      for (int i = 0; i < 4; i++) cyc(0, 0, 1'(i % 2), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
